ethpktgen: RTL and testbench

Synthetic Ethernet frame source that drives the transmit AXI-stream input of the 1G MAC (`tx_axis_*`), acting as the initiator on that interface. It produces back-to-back test frames with a fixed header, a sequence number and a PRBS payload, and supports a programmable length sweep and frame count, for bring-up and throughput benchmarking. FCS, preamble and padding are left to the MAC.

---
 rtl/ethpktgen_if.sv | 20 ++
 rtl/ethpktgen.sv | 226 ++++++++++++++++++++++
 tb/tb_ethpktgen.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ethpktgen_if.sv
// Transmit AXI-stream bundle between the frame generator (master) and the MAC (slave).
interface ethpktgen_if #(
  parameter int DW = 8
);
  logic [DW-1:0] tx_axis_tdata;
  logic          tx_axis_tvalid;
  logic          tx_axis_tready;
  logic          tx_axis_tlast;
  logic          tx_axis_tuser;

  modport master (
    output tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser,
    input  tx_axis_tready
  );

  modport slave (
    input  tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser,
    output tx_axis_tready
  );
endinterface

// File: rtl/ethpktgen.sv
// Test frame source (broadcast header, sequence number, PRBS payload, length sweep) with registered AXI outputs.
// One byte per handshake, tdata held while tready=0; ETHPKTGEN_ERR_INJECT_EN enables errored-frame injection.
module ethpktgen #(
  parameter int DW      = 8,
  parameter int MIN_LEN = 16,
  parameter int MAX_LEN = 1514,
  parameter int LEN_W   = 11
) (
  input  logic             tx_clk,
  input  logic             tx_rst_n,
  input  logic             cfg_enable,
  input  logic [LEN_W-1:0] cfg_len_min,
  input  logic [LEN_W-1:0] cfg_len_max,
  input  logic [15:0]      cfg_count,
  input  logic [47:0]      cfg_src_mac,
  input  logic             err_inject,
  ethpktgen_if.master      tx_axis,
  output logic             busy,
  output logic             done,
  output logic [31:0]      stat_frames,
  output logic [15:0]      stat_err_frames
);

`ifdef ETHPKTGEN_ERR_INJECT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, HDR, PAY, DONE} state_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] v);
    logic [LEN_W-1:0] r;
    r = v;
    if (v < LEN_W'(MIN_LEN)) r = LEN_W'(MIN_LEN);
    if (v > LEN_W'(MAX_LEN)) r = LEN_W'(MAX_LEN);
    return r;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [LEN_W-1:0] i, input logic [47:0] src,
                                            input logic [15:0] seq, input logic [7:0] prbs);
    logic [7:0] b;
    case (int'(i))
      0, 1, 2, 3, 4, 5: b = 8'hFF;
      6:       b = src[47:40];
      7:       b = src[39:32];
      8:       b = src[31:24];
      9:       b = src[23:16];
      10:      b = src[15:8];
      11:      b = src[7:0];
      12:      b = 8'h88;
      13:      b = 8'hB5;
      14:      b = seq[15:8];
      15:      b = seq[7:0];
      default: b = prbs;
    endcase
    return b;
  endfunction

  state_t           state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [15:0]      run_cnt_q, run_cnt_d;
  logic [15:0]      count_q, count_d;
  logic [47:0]      src_q, src_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             first_q, first_d;
  logic             err_pend_q, err_pend_d;
  logic             err_frame_q, err_frame_d;
  logic [DW-1:0]    tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             tuser_q, tuser_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      frames_q, frames_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic [LEN_W-1:0] eff_min, eff_max_c, eff_max, len_inc, start_len;
  logic             hs;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    run_cnt_d   = run_cnt_q;
    count_d     = count_q;
    src_d       = src_q;
    lfsr_d      = lfsr_q;
    first_d     = first_q;
    err_pend_d  = err_pend_q | (ERR_EN & err_inject);
    err_frame_d = err_frame_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;
    busy_d      = busy_q;
    done_d      = done_q;
    frames_d    = frames_q;
    err_cnt_d   = err_cnt_q;

    eff_min   = clamp_len(cfg_len_min);
    eff_max_c = clamp_len(cfg_len_max);
    eff_max   = (eff_max_c < eff_min) ? eff_min : eff_max_c;
    len_inc   = len_q + LEN_W'(1);
    // A config change between frames can leave len_q outside the new window; restart the sweep then.
    start_len = (first_q || len_inc > eff_max || len_inc < eff_min) ? eff_min : len_inc;
    hs        = tvalid_q & tx_axis.tx_axis_tready;

    case (state_q)
      IDLE: begin
        if (!cfg_enable) begin
          run_cnt_d = '0;
          first_d   = 1'b1;
          done_d    = 1'b0;
        end else if (cfg_count != 16'd0 && run_cnt_q == cfg_count) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d     = HDR;
          len_d       = start_len;
          first_d     = 1'b0;
          src_d       = cfg_src_mac;
          count_d     = cfg_count;
          idx_d       = '0;
          lfsr_d      = 8'h01;
          err_frame_d = err_pend_q;
          err_pend_d  = ERR_EN & err_inject;
          tvalid_d    = 1'b1;
          tdata_d     = DW'(8'hFF);
          tlast_d     = 1'b0;
          tuser_d     = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
        end
      end
      HDR, PAY: begin
        if (hs) begin
          if (tlast_q) begin
            state_d   = IDLE;
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            tuser_d   = 1'b0;
            busy_d    = 1'b0;
            run_cnt_d = run_cnt_q + 16'd1;
            frames_d  = frames_q + 32'd1;
            if (err_frame_q) err_cnt_d = err_cnt_q + 16'd1;
            done_d    = (count_q != 16'd0) && (run_cnt_q + 16'd1 == count_q);
          end else begin
            idx_d = idx_q + LEN_W'(1);
            if (idx_q >= LEN_W'(16)) lfsr_d = lfsr_next(lfsr_q);
            tdata_d = DW'(frame_byte(idx_d, src_q, run_cnt_q, lfsr_d));
            tlast_d = (idx_d == len_q - LEN_W'(1));
            tuser_d = err_frame_q & (idx_d == len_q - LEN_W'(1));
            if (idx_q == LEN_W'(15)) state_d = PAY;
          end
        end
      end
      DONE: begin
        if (!cfg_enable) begin
          state_d   = IDLE;
          done_d    = 1'b0;
          run_cnt_d = '0;
          first_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      run_cnt_q   <= '0;
      count_q     <= '0;
      src_q       <= '0;
      lfsr_q      <= 8'h01;
      first_q     <= 1'b1;
      err_pend_q  <= 1'b0;
      err_frame_q <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frames_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      run_cnt_q   <= run_cnt_d;
      count_q     <= count_d;
      src_q       <= src_d;
      lfsr_q      <= lfsr_d;
      first_q     <= first_d;
      err_pend_q  <= err_pend_d;
      err_frame_q <= err_frame_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frames_q    <= frames_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign tx_axis.tx_axis_tdata  = tdata_q;
  assign tx_axis.tx_axis_tvalid = tvalid_q;
  assign tx_axis.tx_axis_tlast  = tlast_q;
  assign tx_axis.tx_axis_tuser  = tuser_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign stat_frames            = frames_q;
  assign stat_err_frames        = err_cnt_q;

endmodule

// File: tb/tb_ethpktgen.sv
// Directed bench for ethpktgen: table of run configurations plus enable-drop and reset-mid-frame sequences.
module tb_ethpktgen;
  localparam int LEN_W = 11;

`ifdef ETHPKTGEN_ERR_INJECT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             tx_clk = 1'b0;
  logic             tx_rst_n;
  logic             cfg_enable;
  logic [LEN_W-1:0] cfg_len_min, cfg_len_max;
  logic [15:0]      cfg_count;
  logic [47:0]      cfg_src_mac;
  logic             err_inject;
  logic             busy, done;
  logic [31:0]      stat_frames;
  logic [15:0]      stat_err_frames;

  ethpktgen_if #(.DW(8)) axis ();

  ethpktgen #(.DW(8), .MIN_LEN(16), .MAX_LEN(1514), .LEN_W(LEN_W)) dut (
    .tx_clk          (tx_clk),
    .tx_rst_n        (tx_rst_n),
    .cfg_enable      (cfg_enable),
    .cfg_len_min     (cfg_len_min),
    .cfg_len_max     (cfg_len_max),
    .cfg_count       (cfg_count),
    .cfg_src_mac     (cfg_src_mac),
    .err_inject      (err_inject),
    .tx_axis         (axis),
    .busy            (busy),
    .done            (done),
    .stat_frames     (stat_frames),
    .stat_err_frames (stat_err_frames)
  );

  always #5 tx_clk = ~tx_clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx [0:2047];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    int          len_min;
    int          len_max;
    int          count;
    logic [47:0] src;
    bit          stall;
    int          nfr;
    int          exp_len [4];
  } vec_t;

  vec_t vec [5];

  function automatic int first_mismatch(input int len, input logic [47:0] src, input logic [15:0] seq);
    logic [7:0] s;
    logic [7:0] e;
    s = 8'h01;
    for (int i = 0; i < len; i++) begin
      if (i < 6)        e = 8'hFF;
      else if (i < 12)  e = src[8*(11-i) +: 8];
      else if (i == 12) e = 8'h88;
      else if (i == 13) e = 8'hB5;
      else if (i == 14) e = seq[15:8];
      else if (i == 15) e = seq[7:0];
      else begin
        e = s;
        s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      end
      if (rx[i] !== e) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    tx_rst_n   = 1'b0;
    cfg_enable = 1'b0;
    err_inject = 1'b0;
    axis.tx_axis_tready = 1'b1;
    repeat (2) @(negedge tx_clk);
    tx_rst_n = 1'b1;
    @(negedge tx_clk);
  endtask

  // Receives one frame. drop_at/rst_at/inj_at act after that many beats were captured (-1 = never).
  task automatic get_frame(input bit stall, input int drop_at, input int rst_at, input int inj_at,
                           output int len, output int gap, output int prot_err,
                           output bit tuser_last, output int tuser_mid);
    int   cyc;
    bit   fin, prev_stall;
    logic [7:0] pd;
    logic pl, pu;
    cyc = 0; len = 0; gap = 0; prot_err = 0; tuser_last = 0; tuser_mid = 0;
    fin = 0; prev_stall = 0; pd = '0; pl = 0; pu = 0;
    while (!fin && cyc < 8000) begin
      @(negedge tx_clk);
      cyc++;
      err_inject = 1'b0;
      axis.tx_axis_tready = stall ? ~axis.tx_axis_tready : 1'b1;
      if (!axis.tx_axis_tvalid) begin
        if (prev_stall) prot_err++;
        if (len == 0) gap++;
        prev_stall = 0;
      end else begin
        if (!busy) prot_err++;
        if (prev_stall && (axis.tx_axis_tdata !== pd || axis.tx_axis_tlast !== pl || axis.tx_axis_tuser !== pu))
          prot_err++;
        if (axis.tx_axis_tready) begin
          prev_stall = 0;
          rx[len] = axis.tx_axis_tdata;
          if (axis.tx_axis_tlast) begin
            fin = 1;
            tuser_last = axis.tx_axis_tuser;
          end else if (axis.tx_axis_tuser) begin
            tuser_mid++;
          end
          len++;
          if (len == inj_at)  err_inject = 1'b1;
          if (len == drop_at) cfg_enable = 1'b0;
          if (len == rst_at) begin
            tx_rst_n = 1'b0;
            #1;
            check("rst_tvalid_same_cycle", axis.tx_axis_tvalid, 0);
            check("rst_busy", busy, 0);
            check("rst_stat_frames", stat_frames, 0);
            fin = 1;
          end
        end else begin
          prev_stall = 1;
          pd = axis.tx_axis_tdata;
          pl = axis.tx_axis_tlast;
          pu = axis.tx_axis_tuser;
        end
      end
    end
    if (!fin) check("frame_timeout", 1, 0);
  endtask

  int len, gap, prot, tmid, nvalid;
  bit tlast_u;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{len_min: 64,   len_max: 64,   count: 2, src: 48'h001122334455, stall: 0, nfr: 2, exp_len: '{64, 64, 0, 0}};
    vec[1] = '{len_min: 64,   len_max: 64,   count: 2, src: 48'h001122334455, stall: 1, nfr: 2, exp_len: '{64, 64, 0, 0}};
    vec[2] = '{len_min: 60,   len_max: 62,   count: 4, src: 48'hA1B2C3D4E5F6, stall: 0, nfr: 4, exp_len: '{60, 61, 62, 60}};
    vec[3] = '{len_min: 10,   len_max: 5,    count: 2, src: 48'h020000000001, stall: 0, nfr: 2, exp_len: '{16, 16, 0, 0}};
    vec[4] = '{len_min: 1512, len_max: 2000, count: 4, src: 48'h001122334455, stall: 0, nfr: 4, exp_len: '{1512, 1513, 1514, 1512}};

    cfg_len_min = '0; cfg_len_max = '0; cfg_count = '0; cfg_src_mac = '0;
    for (int v = 0; v < 5; v++) begin
      do_reset();
      if (v == 0) begin
        check("reset_tvalid", axis.tx_axis_tvalid, 0);
        check("reset_tdata", axis.tx_axis_tdata, 0);
        check("reset_tlast", axis.tx_axis_tlast, 0);
        check("reset_tuser", axis.tx_axis_tuser, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_stat_frames", stat_frames, 0);
        check("reset_stat_err", stat_err_frames, 0);
      end
      cfg_len_min = LEN_W'(vec[v].len_min);
      cfg_len_max = LEN_W'(vec[v].len_max);
      cfg_count   = 16'(vec[v].count);
      cfg_src_mac = vec[v].src;
      cfg_enable  = 1'b1;
      for (int f = 0; f < vec[v].nfr; f++) begin
        get_frame(vec[v].stall, -1, -1, (v == 0 && f == 0) ? 5 : -1, len, gap, prot, tlast_u, tmid);
        check($sformatf("v%0d_f%0d_len", v, f), len, vec[v].exp_len[f]);
        check($sformatf("v%0d_f%0d_content", v, f), first_mismatch(len, vec[v].src, 16'(f)), -1);
        check($sformatf("v%0d_f%0d_protocol", v, f), prot, 0);
        check($sformatf("v%0d_f%0d_tuser_mid", v, f), tmid, 0);
        check($sformatf("v%0d_f%0d_tuser_last", v, f), tlast_u, (ERR_EN && v == 0 && f == 1) ? 1 : 0);
        if (f > 0) check($sformatf("v%0d_f%0d_gap", v, f), gap, 0);
        if (v == 0 && f == 0) begin
          check("f0_b16", rx[16], 8'h01);
          check("f0_b17", rx[17], 8'h02);
          check("f0_b18", rx[18], 8'h04);
          check("f0_b19", rx[19], 8'h08);
          check("f0_b20", rx[20], 8'h11);
          check("f0_b6_src_msb", rx[6], 8'h00);
          check("f0_b11_src_lsb", rx[11], 8'h55);
          check("f0_b12_type", rx[12], 8'h88);
        end
        if (v == 0 && f == 1) begin
          check("f1_seq_hi", rx[14], 8'h00);
          check("f1_seq_lo", rx[15], 8'h01);
        end
        @(negedge tx_clk);
        check($sformatf("v%0d_f%0d_idle", v, f), axis.tx_axis_tvalid, 0);
        check($sformatf("v%0d_f%0d_done", v, f), done, (f == vec[v].nfr - 1) ? 1 : 0);
      end
      repeat (3) @(negedge tx_clk);
      check($sformatf("v%0d_done_hold", v), done, 1);
      check($sformatf("v%0d_no_more_tvalid", v), axis.tx_axis_tvalid, 0);
      check($sformatf("v%0d_stat_frames", v), stat_frames, vec[v].nfr);
      check($sformatf("v%0d_stat_err", v), stat_err_frames, (ERR_EN && v == 0) ? 1 : 0);
      cfg_enable = 1'b0;
      repeat (2) @(negedge tx_clk);
      check($sformatf("v%0d_done_cleared", v), done, 0);
    end

    // Enable dropped at beat 20 of an unlimited run: frame completes, nothing follows.
    do_reset();
    cfg_len_min = 64; cfg_len_max = 64; cfg_count = 0; cfg_src_mac = 48'h001122334455;
    cfg_enable = 1'b1;
    get_frame(1'b0, 20, -1, -1, len, gap, prot, tlast_u, tmid);
    check("drop_len", len, 64);
    check("drop_content", first_mismatch(len, 48'h001122334455, 16'd0), -1);
    nvalid = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge tx_clk);
      if (axis.tx_axis_tvalid) nvalid++;
    end
    check("drop_no_tvalid", nvalid, 0);
    check("drop_stat_frames", stat_frames, 1);
    check("drop_done", done, 0);

    // Reset asserted at beat 20: tvalid falls immediately, no tlast afterwards.
    do_reset();
    cfg_enable = 1'b1;
    get_frame(1'b0, -1, 20, -1, len, gap, prot, tlast_u, tmid);
    check("rst_beats", len, 20);
    cfg_enable = 1'b0;
    @(negedge tx_clk);
    tx_rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge tx_clk);
      if (axis.tx_axis_tvalid || axis.tx_axis_tlast) nvalid++;
    end
    check("rst_quiet", nvalid, 0);
    check("rst_stat_after", stat_frames, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
